// File: rtl/slot_allocator.sv
// Lowest-free-slot allocator over a NUM_SLOTS occupancy bitmap, with a one_detector front end.
// Define SLOT_ALLOC_ERR_CHK_EN to add the sticky o_err misuse flag.

module one_detector #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_in_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_all_zero
);
  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    o_idx      = '0;
    o_all_zero = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_in_vec[i]) begin
        o_idx      = IDX_W'(i);
        o_all_zero = 1'b0;
      end
    end
  end
endmodule

module slot_allocator #(
  parameter int NUM_SLOTS = 8,
  parameter int IDX_W     = $clog2(NUM_SLOTS),
  parameter int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_alloc_req,
  output logic             o_alloc_rdy,
  output logic [IDX_W-1:0] o_alloc_idx,
  input  logic             i_free_vld,
  input  logic [IDX_W-1:0] i_free_idx,
  output logic [CNT_W-1:0] o_free_cnt,
  output logic             o_full
`ifdef SLOT_ALLOC_ERR_CHK_EN
  ,
  output logic             o_err
`endif
);
  logic [NUM_SLOTS-1:0] free_vec, free_oh, alloc_oh, vec_nxt;
  logic                 all_zero, alloc_fire, idx_ok, eff_free;
  logic [CNT_W-1:0]     cnt_nxt;

  one_detector #(.WIDTH(NUM_SLOTS), .IDX_W(IDX_W)) u_det (
    .i_in_vec  (free_vec),
    .o_idx     (o_alloc_idx),
    .o_all_zero(all_zero)
  );

  assign o_alloc_rdy = ~all_zero;
  assign alloc_fire  = i_alloc_req & o_alloc_rdy;
  assign idx_ok      = 32'(i_free_idx) < 32'(NUM_SLOTS);

  // One-hot views keep out-of-range indices from ever touching the bitmap.
  assign free_oh  = (i_free_vld && idx_ok) ? (NUM_SLOTS'(1) << i_free_idx) : '0;
  assign alloc_oh = alloc_fire ? (NUM_SLOTS'(1) << o_alloc_idx) : '0;
  assign eff_free = |(free_oh & ~free_vec & ~alloc_oh);
  assign vec_nxt  = (free_vec | free_oh) & ~alloc_oh;
  assign cnt_nxt  = o_free_cnt + CNT_W'(eff_free) - CNT_W'(alloc_fire);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      free_vec   <= '1;
      o_free_cnt <= CNT_W'(NUM_SLOTS);
      o_full     <= 1'b0;
    end else if (i_flush) begin
      free_vec   <= '1;
      o_free_cnt <= CNT_W'(NUM_SLOTS);
      o_full     <= 1'b0;
    end else begin
      free_vec   <= vec_nxt;
      o_free_cnt <= cnt_nxt;
      o_full     <= (cnt_nxt == '0);
    end
  end

`ifdef SLOT_ALLOC_ERR_CHK_EN
  logic misuse;
  assign misuse = i_free_vld & (~idx_ok | (|(free_oh & free_vec)));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                   o_err <= 1'b0;
    else if (!i_flush && misuse) o_err <= 1'b1;
  end
`endif
endmodule
